// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM generator with double-buffered duty/period and per-channel cycle-end pulse.
// Optional output polarity control is enabled with `define PWM_POLARITY_EN.
module pwm_multi_ctrl #(
  parameter int unsigned CH = 4,
  parameter int unsigned W  = 28
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [CH*W-1:0] DUTY_IN,
  input  logic [CH*W-1:0] PERIOD_IN,
  input  logic [CH-1:0] LOAD,
  input  logic [CH-1:0] EN,
`ifdef PWM_POLARITY_EN
  input  logic [CH-1:0] POL,
`endif
  output logic [CH-1:0] PWM_OUT,
  output logic [CH-1:0] CYCLE_END,
  output logic [CH-1:0] PEND
);

  logic [W-1:0] cnt_q      [CH];
  logic [W-1:0] cnt_d      [CH];
  logic [W-1:0] act_duty_q [CH];
  logic [W-1:0] act_duty_d [CH];
  logic [W-1:0] act_per_q  [CH];
  logic [W-1:0] act_per_d  [CH];
  logic [W-1:0] pnd_duty_q [CH];
  logic [W-1:0] pnd_duty_d [CH];
  logic [W-1:0] pnd_per_q  [CH];
  logic [W-1:0] pnd_per_d  [CH];
  logic [W-1:0] last_c     [CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic [CH-1:0] ce_q, ce_d;
  logic [CH-1:0] run_c, wrap_c, apply_c;
  logic [CH-1:0] pol_c;

`ifdef PWM_POLARITY_EN
  assign pol_c = POL;
`else
  assign pol_c = '0;
`endif

  // Per-channel run/wrap/apply decode
  for (genvar g = 0; g < int'(CH); g++) begin : g_ch
    assign last_c[g]  = act_per_q[g] - W'(1);
    assign run_c[g]   = EN[g] && (act_per_q[g] != '0);
    assign wrap_c[g]  = run_c[g] && (cnt_q[g] == last_c[g]);
    assign apply_c[g] = wrap_c[g] || !run_c[g];
  end

  // Next-state: counter, outputs, and the pending/active buffer handoff
  always_comb begin
    cnt_d      = cnt_q;
    act_duty_d = act_duty_q;
    act_per_d  = act_per_q;
    pnd_duty_d = pnd_duty_q;
    pnd_per_d  = pnd_per_q;
    pend_d     = pend_q;
    pwm_d      = '0;
    ce_d       = '0;
    for (int i = 0; i < int'(CH); i++) begin
      pwm_d[i] = (run_c[i] && (cnt_q[i] < act_duty_q[i])) ^ pol_c[i];
      ce_d[i]  = wrap_c[i];
      cnt_d[i] = (run_c[i] && !wrap_c[i]) ? cnt_q[i] + W'(1) : '0;
      if (apply_c[i] && pend_q[i]) begin
        // A write landing on the apply edge supersedes the stale pending value
        pend_d[i] = 1'b0;
        if (LOAD[i]) begin
          act_duty_d[i] = DUTY_IN[i*W +: W];
          act_per_d[i]  = PERIOD_IN[i*W +: W];
        end else begin
          act_duty_d[i] = pnd_duty_q[i];
          act_per_d[i]  = pnd_per_q[i];
        end
      end else if (LOAD[i]) begin
        pnd_duty_d[i] = DUTY_IN[i*W +: W];
        pnd_per_d[i]  = PERIOD_IN[i*W +: W];
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(CH); i++) begin
        cnt_q[i]      <= '0;
        act_duty_q[i] <= '0;
        act_per_q[i]  <= '0;
        pnd_duty_q[i] <= '0;
        pnd_per_q[i]  <= '0;
      end
      pend_q <= '0;
      pwm_q  <= '0;
      ce_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      act_duty_q <= act_duty_d;
      act_per_q  <= act_per_d;
      pnd_duty_q <= pnd_duty_d;
      pnd_per_q  <= pnd_per_d;
      pend_q     <= pend_d;
      pwm_q      <= pwm_d;
      ce_q       <= ce_d;
    end
  end

  assign PWM_OUT   = pwm_q;
  assign CYCLE_END = ce_q;
  assign PEND      = pend_q;

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// Scoreboard bench for pwm_multi_ctrl: a default 4x28 instance and an 8x8 instance.
module tb_pwm_multi_ctrl;
  localparam int unsigned CHA = 4;
  localparam int unsigned WA  = 28;
  localparam int unsigned CHB = 8;
  localparam int unsigned WB  = 8;

  typedef struct {
    string      tag;
    logic [3:0] pwm, ce, pend;
    logic [7:0] pwm8, ce8, pend8;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [CHA*WA-1:0] duty_a, per_a;
  logic [CHA-1:0] load_a, en_a, pwm_a, ce_a, pend_a;
  logic [CHB*WB-1:0] duty_b, per_b;
  logic [CHB-1:0] load_b, en_b, pwm_b, ce_b, pend_b;
`ifdef PWM_POLARITY_EN
  logic [CHA-1:0] pol_a;
  logic [CHB-1:0] pol_b;
`endif

  pwm_multi_ctrl #(.CH(CHA), .W(WA)) u_dut (
    .CLK(clk), .RST(rst), .DUTY_IN(duty_a), .PERIOD_IN(per_a),
    .LOAD(load_a), .EN(en_a),
`ifdef PWM_POLARITY_EN
    .POL(pol_a),
`endif
    .PWM_OUT(pwm_a), .CYCLE_END(ce_a), .PEND(pend_a));

  pwm_multi_ctrl #(.CH(CHB), .W(WB)) u_dut8 (
    .CLK(clk), .RST(rst), .DUTY_IN(duty_b), .PERIOD_IN(per_b),
    .LOAD(load_b), .EN(en_b),
`ifdef PWM_POLARITY_EN
    .POL(pol_b),
`endif
    .PWM_OUT(pwm_b), .CYCLE_END(ce_b), .PEND(pend_b));

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] e_pwm, e_ce, e_pend;
  logic [7:0] e_pwm8, e_ce8, e_pend8;

  task automatic chk(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h at %0t", name, field, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "pwm_a",  8'(pwm_a),  8'(e.pwm));
        chk(e.tag, "ce_a",   8'(ce_a),   8'(e.ce));
        chk(e.tag, "pend_a", 8'(pend_a), 8'(e.pend));
        chk(e.tag, "pwm_b",  pwm_b,  e.pwm8);
        chk(e.tag, "ce_b",   ce_b,   e.ce8);
        chk(e.tag, "pend_b", pend_b, e.pend8);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic clr_exp();
    e_pwm = '0; e_ce = '0; e_pend = '0;
    e_pwm8 = '0; e_ce8 = '0; e_pend8 = '0;
  endtask

  task automatic cyc(input string tag);
    exp_t e;
    e.tag = tag;
    e.pwm = e_pwm; e.ce = e_ce; e.pend = e_pend;
    e.pwm8 = e_pwm8; e.ce8 = e_ce8; e.pend8 = e_pend8;
`ifdef PWM_POLARITY_EN
    if (!rst) begin
      e.pwm  = e.pwm ^ pol_a;
      e.pwm8 = e.pwm8 ^ pol_b;
    end
`endif
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_a(input int ch, input int d, input int p);
    duty_a[ch*WA +: WA] = WA'(d);
    per_a[ch*WA +: WA]  = WA'(p);
  endtask

  task automatic set_b(input int ch, input int d, input int p);
    duty_b[ch*WB +: WB] = WB'(d);
    per_b[ch*WB +: WB]  = WB'(p);
  endtask

  // Channel-0 running period with hand-chosen D/P; k is the counter value at the edge
  task automatic run0(input string tag, input int n, input int d, input int p);
    for (int k = 0; k < n; k++) begin
      e_pwm[0] = (k % p) < d;
      e_ce[0]  = (k % p) == p - 1;
      cyc(tag);
    end
  endtask

  int bd[8] = '{3, 254, 1, 5, 1, 0, 9, 100};
  int bp[8] = '{10, 255, 1, 7, 2, 4, 6, 150};

  initial begin
    rst = 1'b1;
    duty_a = '0; per_a = '0; load_a = '0; en_a = '0;
    duty_b = '0; per_b = '0; load_b = '0; en_b = '0;
`ifdef PWM_POLARITY_EN
    pol_a = '1; pol_b = '1;
`endif
    clr_exp();
    @(negedge clk);
    cyc("reset");
    cyc("reset");
    rst = 1'b0;

    // Basic waveform: P=10, D=3
    load_a[0] = 1'b1; set_a(0, 3, 10); e_pend = 4'b0001;
    cyc("t1_load");
    load_a = '0; en_a[0] = 1'b1; e_pend = '0;
    cyc("t1_apply");
    run0("t1_run", 30, 3, 10);

    // Double buffer: load D=7/P=20 at cnt=4
    for (int k = 0; k < 10; k++) begin
      load_a[0] = (k == 4);
      if (k == 4) set_a(0, 7, 20);
      e_pwm[0] = k < 3; e_ce[0] = k == 9; e_pend[0] = (k >= 4) && (k < 9);
      cyc("t2_old");
    end
    load_a = '0; e_pend = '0;
    run0("t2_new", 20, 7, 20);

    // Pending D=5, then LOAD D=2 on the wrap edge bypasses it
    for (int k = 0; k < 20; k++) begin
      load_a[0] = (k == 2) || (k == 19);
      if (k == 2)  set_a(0, 5, 20);
      if (k == 19) set_a(0, 2, 20);
      e_pwm[0] = k < 7; e_ce[0] = k == 19; e_pend[0] = (k >= 2) && (k < 19);
      cyc("t4_old");
    end
    load_a = '0; e_pend = '0;
    run0("t4_new", 20, 2, 20);

    // Enable drop at cnt=5, restart from a full period, then reset at cnt=6
    run0("t5_pre", 5, 2, 20);
    en_a[0] = 1'b0; e_pwm = '0; e_ce = '0;
    cyc("t5_drop");
    for (int k = 0; k < 3; k++) cyc("t5_idle");
    en_a[0] = 1'b1;
    run0("t5_restart", 20, 2, 20);
    for (int k = 0; k < 6; k++) begin
      load_a[0] = (k == 3);
      if (k == 3) set_a(0, 9, 20);
      e_pwm[0] = k < 2; e_ce[0] = 1'b0; e_pend[0] = k >= 3;
      cyc("t5_pre_rst");
    end
    rst = 1'b1; load_a = '0; clr_exp();
    cyc("t5_rst");
    rst = 1'b0;
    cyc("t5_post");

    // Boundary duties: ch1 D=0, ch2 D=P, ch3 D>P, ch0 enabled with P=0
    en_a = 4'b1111; load_a = 4'b1110;
    set_a(1, 0, 10); set_a(2, 10, 10); set_a(3, 15, 10);
    e_pend = 4'b1110;
    cyc("t3_load");
    load_a = '0; e_pend = '0;
    cyc("t3_apply");
    for (int t = 0; t < 20; t++) begin
      e_pwm = 4'b1100;
      e_ce  = ((t % 10) == 9) ? 4'b1110 : 4'b0000;
      cyc("t3_run");
    end
    en_a = '0; clr_exp();
    cyc("t3_idle");

    // 8x8 instance: independent channels incl. P=255/D=254 and P=1
    load_b = '1; en_b = '1;
    for (int c = 0; c < 8; c++) set_b(c, bd[c], bp[c]);
    e_pend8 = '1;
    cyc("t6_load");
    load_b = '0; e_pend8 = '0;
    cyc("t6_apply");
    for (int t = 0; t < 520; t++) begin
      for (int c = 0; c < 8; c++) begin
        e_pwm8[c] = (t % bp[c]) < bd[c];
        e_ce8[c]  = (t % bp[c]) == bp[c] - 1;
      end
      cyc("t6_run");
    end
    en_b = '0; clr_exp();
    cyc("t6_idle");

    @(posedge clk);
    #2;
    chk("drain", "queue_left", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ctrl.md
Name: pwm_multi_ctrl

Overview:
Parametrised multi-channel PWM generator, the successor to the fixed 4-channel, 28-bit PWM array fed by Nios PIO exports. Each channel has its own period counter and duty compare. Duty and period are double-buffered, so software writes land glitch-free on a period boundary. Each channel also emits a cycle-end pulse that can drive interrupts or PIO edge capture.

Parameters:
CH, 4, number of independent PWM channels (1..16)
W, 28, width of the duty, period and counter values in bits (2..32)

Ports:
CLK  in  1  system clock
RST  in  1  synchronous reset, active-high
DUTY_IN  in  CH*W  per-channel duty value; channel i is bits [i*W+W-1 : i*W]
PERIOD_IN  in  CH*W  per-channel period value in CLK cycles; same packing as DUTY_IN
LOAD  in  CH  per-channel write strobe; captures DUTY_IN/PERIOD_IN slice i into the pending buffer
EN  in  CH  per-channel run enable
PWM_OUT  out  CH  registered PWM outputs
CYCLE_END  out  CH  one-cycle pulse when the channel wraps its counter
PEND  out  CH  1 while the channel holds a captured but not yet applied value

Behaviour:
- Interface: one clock CLK; reset RST is synchronous, active-high. All state updates on the rising edge of CLK.
- Reset: all counters, active duty/period, pending duty/period, PEND, PWM_OUT and CYCLE_END go to 0.
- Per-channel registers:
  - cnt[W]
  - act_duty[W], act_per[W]
  - pnd_duty[W], pnd_per[W]
  - pend flag
- Channels are fully independent; no cross-channel interaction.
- Run condition: run = EN[i] && act_per != 0.
- Each edge with run=1:
  - PWM_OUT <= (cnt < act_duty)
  - CYCLE_END <= (cnt == act_per-1)
  - cnt <= (cnt == act_per-1) ? 0 : cnt+1
- Each edge with run=0: cnt <= 0, PWM_OUT <= 0, CYCLE_END <= 0.
- Output latency: PWM_OUT is high for exactly D consecutive cycles, then low for P-D, repeating with period P. The first high cycle follows the first edge at which run is sampled 1.
- Boundary values:
  - D=0: output constant 0.
  - D>=P: output constant 1 while running.
  - P=1: cnt stays 0; CYCLE_END is high every cycle.
- Compare is unsigned, full W bits; cnt never exceeds act_per-1.
- Load and apply rules:
  - LOAD[i]=1: pnd_duty/pnd_per <= slice i of DUTY_IN/PERIOD_IN; pend <= 1. A later LOAD before apply overwrites (last write wins).
  - Apply point, defined as run && cnt==act_per-1, or run==0:
    - If pend=1: act <= pnd and pend <= 0.
    - If LOAD is also 1 on the same edge: the new inputs go straight to act and pend <= 0 (bypass, no stale apply).
- While run=0, a LOAD takes effect at the next edge (act updated one cycle after the LOAD edge; PEND high for one cycle).
- EN dropped mid-period: output low on the next edge and cnt cleared. On re-enable the channel starts a fresh period from cnt=0.
- RST asserted mid-operation overrides LOAD, EN and apply on that edge.

Optional Feature:
PWM_POLARITY_EN
- Defined: adds input port POL[CH]. Each PWM_OUT[i] is the internal PWM level XOR POL[i], registered, so the idle/disabled level equals POL[i]. POL is sampled every cycle, not buffered. Reset value of PWM_OUT[i] is 0 until the first edge after reset deasserts, then follows POL[i].
- Undefined: no POL port; outputs are active-high with idle level 0.

Test Plan:
1. Basic waveform: RST, then LOAD ch0 with P=10, D=3; EN[0]=1. PWM_OUT[0] repeats 3 high, 7 low; CYCLE_END[0] pulses every 10 cycles, coincident with the last low cycle.
2. Double buffer: ch0 running P=10, D=3; LOAD D=7, P=20 at cnt=4. PEND[0]=1 until the wrap; the current period finishes as 3/7; the next period is 7 high, 13 low; PEND clears at the wrap edge.
3. Boundary duties: D=0 gives constant low; D=10 with P=10 gives constant high; D=15 with P=10 gives constant high; P=0 with EN=1 gives PWM_OUT=0, CYCLE_END=0 and cnt held 0.
4. Simultaneous LOAD at the wrap edge: pending D=5; LOAD D=2 on the cnt==P-1 edge. The next period uses D=2 and PEND=0.
5. Enable/reset mid-period: drop EN at cnt=5, giving PWM_OUT=0 on the next edge; re-enable and the output restarts from a full D high phase. Assert RST at cnt=6 and all outputs and PEND read 0 on the next edge.
6. Width and channel generality: CH=8, W=8, all channels loaded with distinct D/P including P=255, D=254 and P=1. Each channel waveform and CYCLE_END matches a reference model independently; with PWM_POLARITY_EN and POL=1, outputs are inverted and idle high.
